// File: rtl/mem_access_unit.sv
// Load/store unit: aligns store data onto byte lanes, runs a single bus transaction and
// extends load data. Optional misalignment faulting is enabled with LSU_MISALIGN_CHECK_EN.
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        done,
   output logic        fault,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        fault_q, fault_d;
   logic        bus_we_q;
   logic [31:0] bus_addr_q, bus_wdata_q;
   logic [3:0]  bus_be_q;
   logic [1:0]  off_q;
   logic [2:0]  funct3_q;
   logic        latch_en;

   logic        req_valid, misalign;
   logic [1:0]  req_off;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic [31:0] shifted, load_data;

   // Lane decode; the effective offset drops the bits a wider access ignores.
   always_comb begin
      req_be    = 4'b1111;
      req_off   = 2'b00;
      req_wdata = wdata;
      case (funct3[1:0])
         2'b00: begin
            req_be    = 4'b0001 << addr[1:0];
            req_off   = addr[1:0];
            req_wdata = {4{wdata[7:0]}};
         end
         2'b01: begin
            req_be    = 4'b0011 << {addr[1], 1'b0};
            req_off   = {addr[1], 1'b0};
            req_wdata = {2{wdata[15:0]}};
         end
         default: ;
      endcase

      case (funct3)
         3'b000, 3'b001, 3'b010: req_valid = 1'b1;
         3'b100, 3'b101:         req_valid = ~mem_we;
         default:                req_valid = 1'b0;
      endcase

`ifdef LSU_MISALIGN_CHECK_EN
      misalign = ((funct3[1:0] == 2'b01) & addr[0]) |
                 ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
`else
      misalign = 1'b0;
`endif
   end

   always_comb begin
      shifted = bus_rdata >> {off_q, 3'b000};
      case (funct3_q)
         3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_data = {24'd0, shifted[7:0]};
         3'b101:  load_data = {16'd0, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      fault_d  = fault_q;
      latch_en = 1'b0;
      case (state_q)
         StIdle: begin
            if (mem_req) begin
               if (req_valid && !misalign) begin
                  state_d  = StBus;
                  cnt_d    = 8'd0;
                  fault_d  = 1'b0;
                  latch_en = 1'b1;
               end else begin
                  state_d = StResp;
                  fault_d = 1'b1;
               end
            end
         end
         StBus: begin
            if (bus_ack) begin
               state_d = StResp;
               fault_d = 1'b0;
               if (!bus_we_q) rdata_d = load_data;
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
               state_d = StResp;
               fault_d = 1'b1;
               rdata_d = 32'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= 8'd0;
         rdata_q     <= 32'd0;
         fault_q     <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'd0;
         bus_be_q    <= 4'd0;
         bus_wdata_q <= 32'd0;
         off_q       <= 2'd0;
         funct3_q    <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         fault_q <= fault_d;
         if (latch_en) begin
            bus_we_q    <= mem_we;
            bus_addr_q  <= {addr[31:2], 2'b00};
            bus_be_q    <= req_be;
            bus_wdata_q <= req_wdata;
            off_q       <= req_off;
            funct3_q    <= funct3;
         end
      end
   end

   assign rdata     = rdata_q;
   assign stall     = ((state_q == StIdle) & mem_req) | (state_q == StBus);
   assign done      = (state_q == StResp);
   assign fault     = (state_q == StResp) & fault_q;
   assign bus_req   = (state_q == StBus);
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_be    = bus_be_q;
   assign bus_wdata = bus_wdata_q;

endmodule
